// File: rtl/stopwatch_time_counter_pkg.sv
// Shared types and constants for the stopwatch time counter.
//   bcd_digit_t   : one BCD digit (4 bits)
//   time_field_t  : two BCD digits, tens in [7:4], ones in [3:0]
//   BCD_MAX_9/5   : terminal values for decimal and base-6 digits
//   TICK_DIV_DEFAULT : system clocks per centisecond at the production clock
package stopwatch_time_counter_pkg;

  typedef logic [3:0] bcd_digit_t;
  typedef logic [7:0] time_field_t;

  localparam bcd_digit_t BCD_MAX_9 = 4'd9;
  localparam bcd_digit_t BCD_MAX_5 = 4'd5;

  localparam int TICK_DIV_DEFAULT = 1_000_000;

endpackage

// File: rtl/stopwatch_time_counter_bcd_digit_counter.sv
// One BCD digit of the time cascade.
// Ports:
//   i_clock, i_async_rst : clock, asynchronous active-high reset
//   clear                : synchronous zero, wins over inc
//   inc                  : advance by one (carry-in from the lower digit)
//   digit                : registered digit value
//   carry                : combinational carry-out, inc while digit == MAX
// Parameter MAX selects the terminal value (9 or 5).
module bcd_digit_counter
  import stopwatch_time_counter_pkg::*;
#(
  parameter bcd_digit_t MAX = BCD_MAX_9
) (
  input  logic       i_clock,
  input  logic       i_async_rst,
  input  logic       clear,
  input  logic       inc,
  output bcd_digit_t digit,
  output logic       carry
);

  bcd_digit_t digit_q;

  // Values above MAX are only reachable by upset; >= folds them into the
  // normal wrap so they reload 0, without generating a carry.
  always_ff @(posedge i_clock or posedge i_async_rst) begin
    if (i_async_rst) begin
      digit_q <= '0;
    end else if (clear) begin
      digit_q <= '0;
    end else if (inc) begin
      if (digit_q >= MAX) digit_q <= '0;
      else                digit_q <= digit_q + 4'd1;
    end
  end

  assign digit = digit_q;
  assign carry = inc & (digit_q == MAX);

endmodule

// File: rtl/stopwatch_time_counter.sv
// Stopwatch time counter: centisecond prescaler feeding a cascaded BCD
// MM:SS.CC counter, with a one-cycle wrap pulse at 99:59.99 -> 00:00.00.
// Ports:
//   i_clock, i_async_rst : clock, asynchronous active-high reset
//   i_enable             : count enable from the run/halt FSM
//   i_clear              : synchronous clear, priority over enable and lap
//   o_cs, o_sec, o_min   : BCD time fields
//   o_wrap               : one-cycle pulse on full rollover
// Optional (macro STOPWATCH_LAP_EN):
//   i_lap                : capture current time into lap registers
//   o_lap_cs/sec/min     : captured lap time
//   o_lap_valid          : a lap has been captured since last clear/reset
module stopwatch_time_counter
  import stopwatch_time_counter_pkg::*;
#(
  parameter int TICK_DIV   = TICK_DIV_DEFAULT,
  parameter int PRESCALE_W = 20
) (
  input  logic        i_clock,
  input  logic        i_async_rst,
  input  logic        i_enable,
  input  logic        i_clear,
  output time_field_t o_cs,
  output time_field_t o_sec,
  output time_field_t o_min,
  output logic        o_wrap
`ifdef STOPWATCH_LAP_EN
  ,
  input  logic        i_lap,
  output time_field_t o_lap_cs,
  output time_field_t o_lap_sec,
  output time_field_t o_lap_min,
  output logic        o_lap_valid
`endif
);

  localparam logic [PRESCALE_W-1:0] PRESCALE_LAST = PRESCALE_W'(TICK_DIV - 1);

  logic [PRESCALE_W-1:0] prescale;
  logic       tick;
  logic       c_cs0, c_cs1, c_sec0, c_sec1, c_min0, c_min1;
  bcd_digit_t cs0, cs1, sec0, sec1, min0, min1;

  // Prescaler holds its partial count while disabled so halt/resume
  // does not lose sub-centisecond time.
  always_ff @(posedge i_clock or posedge i_async_rst) begin
    if (i_async_rst) begin
      prescale <= '0;
    end else if (i_clear) begin
      prescale <= '0;
    end else if (i_enable) begin
      if (prescale == PRESCALE_LAST) prescale <= '0;
      else                           prescale <= prescale + 1'b1;
    end
  end

  // A tick coinciding with clear is dropped so no carry (and no wrap) fires.
  assign tick = i_enable & ~i_clear & (prescale == PRESCALE_LAST);

  bcd_digit_counter #(.MAX(BCD_MAX_9)) u_cs0 (
    .i_clock(i_clock), .i_async_rst(i_async_rst), .clear(i_clear),
    .inc(tick),   .digit(cs0),  .carry(c_cs0));
  bcd_digit_counter #(.MAX(BCD_MAX_9)) u_cs1 (
    .i_clock(i_clock), .i_async_rst(i_async_rst), .clear(i_clear),
    .inc(c_cs0),  .digit(cs1),  .carry(c_cs1));
  bcd_digit_counter #(.MAX(BCD_MAX_9)) u_sec0 (
    .i_clock(i_clock), .i_async_rst(i_async_rst), .clear(i_clear),
    .inc(c_cs1),  .digit(sec0), .carry(c_sec0));
  bcd_digit_counter #(.MAX(BCD_MAX_5)) u_sec1 (
    .i_clock(i_clock), .i_async_rst(i_async_rst), .clear(i_clear),
    .inc(c_sec0), .digit(sec1), .carry(c_sec1));
  bcd_digit_counter #(.MAX(BCD_MAX_9)) u_min0 (
    .i_clock(i_clock), .i_async_rst(i_async_rst), .clear(i_clear),
    .inc(c_sec1), .digit(min0), .carry(c_min0));
  bcd_digit_counter #(.MAX(BCD_MAX_9)) u_min1 (
    .i_clock(i_clock), .i_async_rst(i_async_rst), .clear(i_clear),
    .inc(c_min0), .digit(min1), .carry(c_min1));

  assign o_cs  = {cs1, cs0};
  assign o_sec = {sec1, sec0};
  assign o_min = {min1, min0};

  // Carry out of the top digit is exactly the 99:59.99 rollover.
  always_ff @(posedge i_clock or posedge i_async_rst) begin
    if (i_async_rst) o_wrap <= 1'b0;
    else             o_wrap <= c_min1;
  end

`ifdef STOPWATCH_LAP_EN
  // Captures the pre-increment value when a tick lands in the same cycle.
  always_ff @(posedge i_clock or posedge i_async_rst) begin
    if (i_async_rst) begin
      o_lap_cs    <= '0;
      o_lap_sec   <= '0;
      o_lap_min   <= '0;
      o_lap_valid <= 1'b0;
    end else if (i_clear) begin
      o_lap_cs    <= '0;
      o_lap_sec   <= '0;
      o_lap_min   <= '0;
      o_lap_valid <= 1'b0;
    end else if (i_lap) begin
      o_lap_cs    <= o_cs;
      o_lap_sec   <= o_sec;
      o_lap_min   <= o_min;
      o_lap_valid <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_stopwatch_time_counter.sv
module tb_stopwatch_time_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] o_cs, o_sec, o_min;
  logic       o_wrap;
`ifdef STOPWATCH_LAP_EN
  logic       lap = 1'b0;
  logic [7:0] o_lap_cs, o_lap_sec, o_lap_min;
  logic       o_lap_valid;
`endif

  int checks = 0;
  int errors = 0;
  int wrap_seen = 0;

  logic [7:0] pl_m, pl_s, pl_c;

  stopwatch_time_counter #(.TICK_DIV(4), .PRESCALE_W(20)) dut (
    .i_clock(clk),
    .i_async_rst(rst),
    .i_enable(en),
    .i_clear(clr),
    .o_cs(o_cs),
    .o_sec(o_sec),
    .o_min(o_min),
    .o_wrap(o_wrap)
`ifdef STOPWATCH_LAP_EN
    ,
    .i_lap(lap),
    .o_lap_cs(o_lap_cs),
    .o_lap_sec(o_lap_sec),
    .o_lap_min(o_lap_min),
    .o_lap_valid(o_lap_valid)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (o_wrap) wrap_seen++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       en;
    logic       clr;
    int         n;
    logic [7:0] cs;
    logic [7:0] sec;
    logic [7:0] mn;
    logic       wrap;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_time(input string nm, input logic [7:0] m, input logic [7:0] s,
                          input logic [7:0] c);
    chk({nm, " time"}, {8'h0, o_min, o_sec, o_cs}, {8'h0, m, s, c});
  endtask

  // Clear (prescaler to 0), then deposit a time value into the digit registers.
  task automatic preload(input logic [7:0] m, input logic [7:0] s, input logic [7:0] c);
    en  = 1'b0;
    clr = 1'b1;
    step(1);
    clr  = 1'b0;
    pl_m = m;
    pl_s = s;
    pl_c = c;
    force dut.u_min1.digit_q = pl_m[7:4];
    force dut.u_min0.digit_q = pl_m[3:0];
    force dut.u_sec1.digit_q = pl_s[7:4];
    force dut.u_sec0.digit_q = pl_s[3:0];
    force dut.u_cs1.digit_q  = pl_c[7:4];
    force dut.u_cs0.digit_q  = pl_c[3:0];
    #1;
    release dut.u_min1.digit_q;
    release dut.u_min0.digit_q;
    release dut.u_sec1.digit_q;
    release dut.u_sec0.digit_q;
    release dut.u_cs1.digit_q;
    release dut.u_cs0.digit_q;
    #1;
  endtask

  // Preload, run one full tick period, check value before and after the tick.
  task automatic one_tick(input string nm,
                          input logic [7:0] pm, input logic [7:0] ps, input logic [7:0] pc,
                          input logic [7:0] em, input logic [7:0] es, input logic [7:0] ec,
                          input logic ew);
    preload(pm, ps, pc);
    en = 1'b1;
    step(3);
    chk_time({nm, " pre"}, pm, ps, pc);
    step(1);
    chk_time({nm, " post"}, em, es, ec);
    chk({nm, " wrap"}, {31'h0, o_wrap}, {31'h0, ew});
    step(1);
    chk({nm, " wrap after"}, {31'h0, o_wrap}, 32'h0);
    en = 1'b0;
  endtask

  int base;

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 40, 8'h10, 8'h00, 8'h00, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1,  8'h00, 8'h00, 8'h00, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 6,  8'h01, 8'h00, 8'h00, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 20, 8'h01, 8'h00, 8'h00, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1,  8'h01, 8'h00, 8'h00, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 1,  8'h02, 8'h00, 8'h00, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 3,  8'h02, 8'h00, 8'h00, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 1,  8'h03, 8'h00, 8'h00, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 1,  8'h00, 8'h00, 8'h00, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 3,  8'h00, 8'h00, 8'h00, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 1,  8'h01, 8'h00, 8'h00, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 99, 8'h25, 8'h00, 8'h00, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 1,  8'h26, 8'h00, 8'h00, 1'b0};

    #2;
    chk_time("reset", 8'h00, 8'h00, 8'h00);
    chk("reset wrap", {31'h0, o_wrap}, 32'h0);
`ifdef STOPWATCH_LAP_EN
    chk("reset lap_valid", {31'h0, o_lap_valid}, 32'h0);
`endif
    #10;
    rst = 1'b0;

    base = wrap_seen;
    for (int i = 0; i < 13; i++) begin
      en  = vecs[i].en;
      clr = vecs[i].clr;
      step(vecs[i].n);
      chk_time($sformatf("vec%0d", i), vecs[i].mn, vecs[i].sec, vecs[i].cs);
      chk($sformatf("vec%0d wrap", i), {31'h0, o_wrap}, {31'h0, vecs[i].wrap});
    end
    clr = 1'b0;
    chk("no wrap during table", wrap_seen - base, 0);

    one_tick("sec carry", 8'h00, 8'h59, 8'h99, 8'h01, 8'h00, 8'h00, 1'b0);
    one_tick("min tens",  8'h09, 8'h59, 8'h99, 8'h10, 8'h00, 8'h00, 1'b0);
    one_tick("wrap",      8'h99, 8'h59, 8'h99, 8'h00, 8'h00, 8'h00, 1'b1);
    one_tick("illegal cs", 8'h00, 8'h00, 8'h3C, 8'h00, 8'h00, 8'h30, 1'b0);

    // Clear in the same cycle as a tick.
    preload(8'h00, 8'h12, 8'h34);
    en = 1'b1;
    step(3);
    clr = 1'b1;
    base = wrap_seen;
    step(1);
    clr = 1'b0;
    chk_time("clear prio", 8'h00, 8'h00, 8'h00);
    chk("clear prio wrap", {31'h0, o_wrap}, 32'h0);
    step(3);
    chk_time("clear presc hold", 8'h00, 8'h00, 8'h00);
    step(1);
    chk_time("clear presc first", 8'h00, 8'h00, 8'h01);
    chk("clear no wrap seen", wrap_seen - base, 0);

`ifdef STOPWATCH_LAP_EN
    preload(8'h00, 8'h03, 8'h27);
    en = 1'b1;
    step(3);
    lap = 1'b1;
    step(1);
    lap = 1'b0;
    chk_time("lap running", 8'h00, 8'h03, 8'h28);
    chk("lap value", {8'h0, o_lap_min, o_lap_sec, o_lap_cs}, 32'h00000327);
    chk("lap valid", {31'h0, o_lap_valid}, 32'h1);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    chk("lap cleared", {7'h0, o_lap_valid, o_lap_min, o_lap_sec, o_lap_cs}, 32'h0);
`endif

    // Asynchronous reset mid-period while the count is nonzero.
    preload(8'h12, 8'h34, 8'h56);
    en = 1'b1;
    step(1);
    #1;
    rst = 1'b1;
    #1;
    chk_time("async rst", 8'h00, 8'h00, 8'h00);
    chk("async rst wrap", {31'h0, o_wrap}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b0;
    step(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
